ysyx_22050710_if_stage_ibuf: RTL and testbench

- Next-generation fetch stage: decoupled pre-IF request engine on a split req/addr_ok/data_ok inst SRAM interface, up to MAX_OUTSTANDING in-flight fetches, parametrised FIFO_DEPTH instruction buffer feeding ID.
- Sits between the inst SRAM bridge and the ID stage. Branch redirect from ID flushes the buffer and cancels stale in-flight responses.

---
 rtl/ysyx_22050710_if_stage_ibuf.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22050710_if_stage_ibuf.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_if_stage_ibuf.sv
// ysyx_22050710_if_stage_ibuf
//   Decoupled fetch stage. A pre-IF engine issues requests on a split
//   req/addr_ok/data_ok inst SRAM interface, keeping up to MAX_OUTSTANDING
//   fetches in flight. Responses land in a FIFO_DEPTH-entry instruction buffer
//   that feeds ID. A branch from ID flushes the buffer, redirects the fetch PC
//   and marks every in-flight response as stale so that it is dropped on return.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ds_allowin          ID takes the buffer head this cycle
//   i_br_bus              {br_taken, br_target}
//   o_fs_to_ds_valid      buffer head valid
//   o_fs_to_ds_bus        {inst, pc} of the buffer head
//   o_inst_sram_req       fetch request
//   o_inst_sram_addr      fetch PC with bits [2:0] cleared (64-bit beat)
//   i_inst_sram_addr_ok   request accepted this cycle
//   i_inst_sram_data_ok   oldest response returned this cycle
//   i_inst_sram_rdata     response beat (two instructions, picked by pc[2])
//
// Handshakes: a request transfers in a cycle where o_inst_sram_req and
// i_inst_sram_addr_ok are both high; req and addr stay stable until then.
// A buffer entry transfers to ID in a cycle where o_fs_to_ds_valid and
// i_ds_allowin are both high; the head stays stable until then.
module ysyx_22050710_if_stage_ibuf #(
  parameter int                 INST_WD         = 32,
  parameter int                 PC_WD           = 64,
  parameter logic [PC_WD-1:0]   PC_RESETVAL     = 64'h8000_0000,
  parameter int                 SRAM_ADDR_WD    = 64,
  parameter int                 SRAM_DATA_WD    = 64,
  parameter int                 FIFO_DEPTH      = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter int                 FS_TO_DS_BUS_WD = INST_WD + PC_WD,
  parameter int                 BR_BUS_WD       = PC_WD + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ds_allowin,
  input  logic [BR_BUS_WD-1:0]       i_br_bus,
  output logic                       o_fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] o_fs_to_ds_bus,
  output logic                       o_inst_sram_req,
  output logic [SRAM_ADDR_WD-1:0]    o_inst_sram_addr,
  input  logic                       i_inst_sram_addr_ok,
  input  logic                       i_inst_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]    i_inst_sram_rdata
);

  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PQ_W-1:0]  PQ_LAST  = PQ_W'(MAX_OUTSTANDING - 1);
  localparam logic [PC_WD-1:0] BEAT_MSK = ~PC_WD'(7);
  localparam logic [PC_WD-1:0] WORD_MSK = ~PC_WD'(3);

  logic             br_taken;
  logic [PC_WD-1:0] br_target;
  assign {br_taken, br_target} = i_br_bus;

  // Fetch PC, in-flight PC queue, counters and instruction buffer.
  logic [PC_WD-1:0]           pf_pc_q, pf_pc_d;
  logic [PC_WD-1:0]           pq_mem_q [MAX_OUTSTANDING];
  logic [PC_WD-1:0]           pq_mem_d [MAX_OUTSTANDING];
  logic [PQ_W-1:0]            pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [CNT_W-1:0]           out_q, out_d;
  logic [CNT_W-1:0]           cancel_q, cancel_d;
  logic [FS_TO_DS_BUS_WD-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [FS_TO_DS_BUS_WD-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [FA_W-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic               credit_ok, addr_hs, resp, keep, pop;
  logic [PC_WD-1:0]   resp_pc;
  logic [INST_WD-1:0] resp_inst;

  function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
    return (p == PQ_LAST) ? '0 : p + PQ_W'(1);
  endfunction

  always_comb begin
    // Cancelled requests still occupy in-flight slots and buffer credit.
    credit_ok = (out_q < MAX_OUT) && (({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_X);
    o_inst_sram_req  = !i_rst && !br_taken && credit_ok;
    o_inst_sram_addr = i_rst ? SRAM_ADDR_WD'(PC_RESETVAL & BEAT_MSK)
                             : SRAM_ADDR_WD'(pf_pc_q & BEAT_MSK);
    addr_hs = o_inst_sram_req && i_inst_sram_addr_ok;

    // data_ok with nothing in flight is a bridge protocol error and is ignored.
    resp      = i_inst_sram_data_ok && (out_q != '0);
    resp_pc   = pq_mem_q[pq_rd_q];
    resp_inst = resp_pc[2] ? i_inst_sram_rdata[2*INST_WD-1:INST_WD]
                           : i_inst_sram_rdata[INST_WD-1:0];
    keep      = resp && (cancel_q == '0) && !br_taken;

    // Head comes straight from registered state: no path from data_ok.
    o_fs_to_ds_valid = (cnt_q != '0) && !br_taken && !i_rst;
    o_fs_to_ds_bus   = fifo_mem_q[rd_q];
    pop              = o_fs_to_ds_valid && i_ds_allowin;

    pf_pc_d = pf_pc_q;
    if (br_taken)     pf_pc_d = br_target & WORD_MSK;
    else if (addr_hs) pf_pc_d = pf_pc_q + PC_WD'(4);

    pq_mem_d = pq_mem_q;
    pq_wr_d  = pq_wr_q;
    pq_rd_d  = pq_rd_q;
    if (addr_hs) begin
      pq_mem_d[pq_wr_q] = pf_pc_q;
      pq_wr_d           = pq_next(pq_wr_q);
    end
    if (resp) pq_rd_d = pq_next(pq_rd_q);

    out_d = out_q + CNT_W'(addr_hs) - CNT_W'(resp);

    // A branch makes every still-unanswered request stale; reload, not add.
    cancel_d = cancel_q;
    if (br_taken)                       cancel_d = out_q - CNT_W'(resp);
    else if (resp && cancel_q != '0)    cancel_d = cancel_q - CNT_W'(1);

    fifo_mem_d = fifo_mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (br_taken) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (keep) begin
        fifo_mem_d[wr_q] = {resp_inst, resp_pc};
        wr_d             = wr_q + FA_W'(1);
      end
      if (pop) rd_d = rd_q + FA_W'(1);
      cnt_d = cnt_q + CNT_W'(keep) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pf_pc_q  <= PC_RESETVAL;
      pq_wr_q  <= '0;
      pq_rd_q  <= '0;
      out_q    <= '0;
      cancel_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pf_pc_q  <= pf_pc_d;
      pq_wr_q  <= pq_wr_d;
      pq_rd_q  <= pq_rd_d;
      out_q    <= out_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
    pq_mem_q   <= pq_mem_d;
    fifo_mem_q <= fifo_mem_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_inst_sram_data_ok && out_q == '0));
      assert (!(keep && !pop && cnt_q == DEPTH_C));
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_if_stage_ibuf.sv
module tb_ysyx_22050710_if_stage_ibuf;

  localparam int MAX_OUT = 2;
  localparam int DEPTH   = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ds_allowin;
  logic [64:0] br_bus;
  logic        fs_valid;
  logic [95:0] fs_bus;
  logic        req;
  logic [63:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  ysyx_22050710_if_stage_ibuf dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ds_allowin        (ds_allowin),
    .i_br_bus            (br_bus),
    .o_fs_to_ds_valid    (fs_valid),
    .o_fs_to_ds_bus      (fs_bus),
    .o_inst_sram_req     (req),
    .o_inst_sram_addr    (addr),
    .i_inst_sram_addr_ok (addr_ok),
    .i_inst_sram_data_ok (data_ok),
    .i_inst_sram_rdata   (rdata)
  );

  // ---------------- reference model ----------------
  // Memory image: the instruction at pc is a fixed function of pc, so a beat
  // at aligned address a carries inst_of(a) low and inst_of(a+4) high.
  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h5a5a_c3c3;
  endfunction

  function automatic logic [63:0] beat_of(input logic [63:0] a);
    return {inst_of(a + 64'd4), inst_of(a)};
  endfunction

  typedef struct {
    logic [63:0] addr;
    bit          stale;
  } inflight_t;

  inflight_t   bridge_q[$];   // accepted, unanswered requests (bridge side)
  logic [63:0] exp_q[$];      // pcs ID must see, in order
  logic [63:0] exp_req_pc;    // pc of the next request to be accepted
  int          fifo_m;        // entries sitting in the buffer
  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  logic [63:0] last_pop_pc;

  task automatic model_reset();
    bridge_q.delete();
    exp_q.delete();
    fifo_m     = 0;
    exp_req_pc = RESET_PC;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic do_cycle(input bit br, input logic [63:0] tgt,
                          input int aok, input int dok, input int alw);
    logic        exp_req, exp_valid;
    inflight_t   e;
    ds_allowin = ($urandom_range(0, 99) < alw);
    addr_ok    = ($urandom_range(0, 99) < aok);
    data_ok    = (bridge_q.size() > 0) && ($urandom_range(0, 99) < dok);
    rdata      = data_ok ? beat_of(bridge_q[0].addr) : {$urandom, $urandom};
    br_bus     = {br, tgt};
    @(negedge clk);
    exp_req   = !br && (bridge_q.size() < MAX_OUT) && (bridge_q.size() + fifo_m < DEPTH);
    exp_valid = (fifo_m > 0) && !br;
    tests++;
    if (req !== exp_req) begin
      fails++;
      $display("FAIL req: got %b want %b (t=%0t)", req, exp_req, $time);
    end
    tests++;
    if (fs_valid !== exp_valid) begin
      fails++;
      $display("FAIL valid: got %b want %b (t=%0t)", fs_valid, exp_valid, $time);
    end
    if (exp_req) begin
      tests++;
      if (addr !== (exp_req_pc & ~64'h7)) begin
        fails++;
        $display("FAIL addr: got %h want %h", addr, exp_req_pc & ~64'h7);
      end
    end
    if (exp_valid && exp_q.size() > 0) begin
      tests++;
      if (fs_bus !== {inst_of(exp_q[0]), exp_q[0]}) begin
        fails++;
        $display("FAIL head: got %h want %h", fs_bus, {inst_of(exp_q[0]), exp_q[0]});
      end
    end
    if (fs_valid && ds_allowin) begin
      pops++;
      last_pop_pc = fs_bus[63:0];
    end
    if (exp_valid && ds_allowin) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      fifo_m--;
    end
    if (data_ok) begin
      e = bridge_q.pop_front();
      if (!e.stale && !br) fifo_m++;
    end
    if (exp_req && addr_ok) begin
      bridge_q.push_back('{addr: exp_req_pc & ~64'h7, stale: 1'b0});
      exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 64'd4;
    end
    if (br) begin
      foreach (bridge_q[i]) bridge_q[i].stale = 1'b1;
      exp_q.delete();
      fifo_m     = 0;
      exp_req_pc = {tgt[63:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int aok, input int dok, input int alw);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 64'd0, aok, dok, alw);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((bridge_q.size() > 0 || fifo_m > 0) && k < 60) begin
      do_cycle(1'b0, 64'd0, 0, 100, 100);
      k++;
    end
    tests++;
    if (bridge_q.size() > 0 || fifo_m > 0) begin
      fails++;
      $display("FAIL drain: timeout, %0d in flight %0d buffered", bridge_q.size(), fifo_m);
    end
  endtask

  task automatic expect_next_pop(input string name, input logic [63:0] want);
    int p0;
    p0 = pops;
    for (int i = 0; i < 40 && pops == p0; i++) do_cycle(1'b0, 64'd0, 100, 100, 100);
    tests++;
    if (pops == p0) begin
      fails++;
      $display("FAIL %s: no entry reached ID within 40 cycles, want pc %h", name, want);
    end else if (last_pop_pc !== want) begin
      fails++;
      $display("FAIL %s: first pc got %h want %h", name, last_pop_pc, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (req !== 1'b0 || fs_valid !== 1'b0 || addr !== RESET_PC) begin
        fails++;
        $display("FAIL reset_out: req=%b valid=%b addr=%h want 0 0 %h", req, fs_valid, addr, RESET_PC);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_free_run();
    int p0;
    run(10, 100, 100, 100);
    p0 = pops;
    run(20, 100, 100, 100);
    tests++;
    if (pops - p0 != 20) begin
      fails++;
      $display("FAIL free_run_rate: got %0d pops in 20 cycles want 20", pops - p0);
    end
  endtask

  task automatic test_stall();
    int p0;
    run(10, 100, 100, 0);
    tests++;
    if (req !== 1'b0 || fs_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_full: req=%b valid=%b want 0 1", req, fs_valid);
    end
    p0 = pops;
    run(4, 0, 100, 100);
    tests++;
    if (pops - p0 != DEPTH) begin
      fails++;
      $display("FAIL stall_count: got %0d buffered want %0d", pops - p0, DEPTH);
    end
    run(20, 100, 100, 100);
  endtask

  task automatic test_branch();
    drain();
    run(2, 100, 0, 100);
    do_cycle(1'b1, 64'h8000_1002, 100, 0, 100);
    expect_next_pop("branch_target", 64'h8000_1000);
  endtask

  task automatic test_branch_data_ok();
    drain();
    run(2, 100, 0, 100);
    do_cycle(1'b1, 64'h8000_2004, 100, 100, 100);
    expect_next_pop("branch_dok_target", 64'h8000_2004);
  endtask

  task automatic test_addr_stall();
    logic [63:0] a0;
    drain();
    a0 = exp_req_pc & ~64'h7;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 64'd0, 0, 100, 100);
      @(negedge clk);
      tests++;
      if (req !== 1'b1 || addr !== a0) begin
        fails++;
        $display("FAIL addr_stall: req=%b addr=%h want 1 %h", req, addr, a0);
      end
      @(posedge clk);
      #1;
    end
    run(10, 100, 100, 100);
  endtask

  task automatic test_reset_mid();
    run(2, 100, 0, 0);
    run(1, 0, 100, 0);
    run(1, 100, 0, 0);
    test_reset();
    expect_next_pop("reset_mid_first", RESET_PC);
  endtask

  task automatic test_wrap();
    drain();
    do_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 100, 100, 100);
    expect_next_pop("wrap_first", 64'hFFFF_FFFF_FFFF_FFF4);
    run(12, 100, 100, 100);
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)}
                                          : {$urandom, $urandom};
        do_cycle(1'b1, tgt, 60, 50, 60);
      end else begin
        do_cycle(1'b0, 64'd0, $urandom_range(20, 100), $urandom_range(20, 100),
                 $urandom_range(0, 100));
      end
    end
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_data_ok();
    test_addr_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
